// File: rtl/sa_pkg.sv
// Shared definitions for the output-stationary systolic array.
// FSM state encoding, derived-size helpers and the result-lane index helper.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sa_state_e;

  // Sizes of the default 8x8 array; instances derive their own through the helpers below.
  localparam int DEF_NUM_ROW   = 8;
  localparam int DEF_NUM_COL   = 8;
  localparam int DEF_IN_W      = 8;
  localparam int DRAIN_CYC     = DEF_NUM_ROW + DEF_NUM_COL - 1;
  localparam int PROD_W        = 2 * DEF_IN_W;

  // Cycles needed after the last beat until the far-corner PE has accumulated it.
  function automatic int drain_cyc(input int num_row, input int num_col);
    return num_row + num_col - 1;
  endfunction

  // Full-precision product width for a given operand width.
  function automatic int prod_w(input int in_w);
    return 2 * in_w;
  endfunction

  // Flat lane index of C[r][c] inside the result bus.
  function automatic int res_idx(input int r, input int c, input int num_col);
    return r * num_col + c;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One MAC processing element: registers x/w/valid on entry, forwards them to the
// right/lower neighbour, and accumulates x*w whenever both operands are tagged valid.
// Optional clamping accumulator and sticky overflow flag under SA_SATURATE_EN.
module sa_pe
  import sa_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [IN_W-1:0]  x_i,
  input  logic             x_v_i,
  input  logic [IN_W-1:0]  w_i,
  input  logic             w_v_i,
  output logic [IN_W-1:0]  x_o,
  output logic             x_v_o,
  output logic [IN_W-1:0]  w_o,
  output logic             w_v_o,
  output logic [ACC_W-1:0] acc_o
`ifdef SA_SATURATE_EN
  ,
  output logic             sat_o
`endif
);

  localparam int PW = prod_w(IN_W);

  logic [IN_W-1:0]  x_q, w_q;
  logic             xv_q, wv_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PW-1:0]    x_ext, w_ext, prod;
  logic [ACC_W-1:0] prod_ext;

  // Extend operands to product width so the truncated product is exact in both modes.
  always_comb begin
    if (SIGNED != 0) begin
      x_ext    = {{IN_W{x_q[IN_W-1]}}, x_q};
      w_ext    = {{IN_W{w_q[IN_W-1]}}, w_q};
      prod     = x_ext * w_ext;
      prod_ext = ACC_W'($signed(prod));
    end else begin
      x_ext    = {{IN_W{1'b0}}, x_q};
      w_ext    = {{IN_W{1'b0}}, w_q};
      prod     = x_ext * w_ext;
      prod_ext = ACC_W'(prod);
    end
  end

`ifdef SA_SATURATE_EN
  logic           sat_q, sat_d;
  logic [ACC_W:0] sum_x;
  logic           ovf;

  // Clamping accumulate: overflow detected from operand/result signs or the carry out.
  always_comb begin
    sum_x = {1'b0, acc_q} + {1'b0, prod_ext};
    if (SIGNED != 0) begin
      ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_x[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf = sum_x[ACC_W];
    end
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (xv_q && wv_q) begin
      if (!ovf) begin
        acc_d = sum_x[ACC_W-1:0];
      end else if (SIGNED != 0) begin
        acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = '1;
      end
      if (ovf) sat_d = 1'b1;
    end
  end

  // Sticky overflow flag, cleared with the accumulator when a job starts.
  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_o = sat_q;
`else
  // Wrap-around accumulate modulo 2^ACC_W.
  always_comb begin
    acc_d = acc_q;
    if (clear_i)             acc_d = '0;
    else if (xv_q && wv_q)   acc_d = acc_q + prod_ext;
  end
`endif

  // Operand pass-through registers and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      w_q   <= '0;
      xv_q  <= 1'b0;
      wv_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      x_q   <= x_i;
      w_q   <= w_i;
      xv_q  <= x_v_i;
      wv_q  <= w_v_i;
      acc_q <= acc_d;
    end
  end

  assign x_o   = x_q;
  assign x_v_o = xv_q;
  assign w_o   = w_q;
  assign w_v_o = wv_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/param_systolic_array.sv
// Output-stationary NUM_ROW x NUM_COL systolic array computing C = A*B over k_len beats.
// Holds the job FSM, beat/drain/cycle counters, operand skew chains and the PE grid.
// Optional feature macro: SA_SATURATE_EN (clamping accumulators plus sat_flag output).
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready. in_ready
// is high only in LOAD and does not depend on in_valid; in_valid low in LOAD is a bubble
// that travels through the array tagged invalid and is never accumulated.
module param_systolic_array
  import sa_pkg::*;
#(
  parameter int NUM_ROW = 8,
  parameter int NUM_COL = 8,
  parameter int IN_W    = 8,
  parameter int ACC_W   = 24,
  parameter int K_W     = 8,
  parameter int SIGNED  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [K_W-1:0]                   k_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_ROW*IN_W-1:0]          left_in,
  input  logic [NUM_COL*IN_W-1:0]          top_in,
  output logic                             busy,
  output logic                             done,
  output logic [ACC_W-1:0]                 cycles_count,
  output logic [NUM_ROW*NUM_COL*ACC_W-1:0] result,
  output sa_state_e                        dbg_state
`ifdef SA_SATURATE_EN
  ,
  output logic [NUM_ROW*NUM_COL-1:0]       sat_flag
`endif
);

  localparam int DCYC = drain_cyc(NUM_ROW, NUM_COL);
  localparam int DCW  = $clog2(DCYC + 1);

  sa_state_e      state_q, state_d;
  logic [K_W-1:0] klen_q, klen_d, beat_q, beat_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [ACC_W-1:0] cc_q, cc_d;
  logic           clear, beat_fire;

  assign in_ready     = (state_q == ST_LOAD);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign cycles_count = cc_q;
  assign dbg_state    = state_q;
  assign beat_fire    = in_valid && in_ready;

  // Next-state logic for the job FSM and its counters.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          klen_d  = k_len;
          beat_d  = '0;
          drain_d = '0;
          state_d = (k_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat_fire) begin
          beat_d = beat_q + K_W'(1);
          if (beat_d == klen_q) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DCW'(DCYC - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Job duration counter: zeroed on start, counts non-idle cycles, saturates.
  always_comb begin
    cc_d = cc_q;
    if (state_q == ST_IDLE) begin
      if (start) cc_d = '0;
    end else if (cc_q != '1) begin
      cc_d = cc_q + ACC_W'(1);
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      cc_q    <= cc_d;
    end
  end

  // Skewed operand lanes feeding the grid edges.
  logic [IN_W-1:0] lx [NUM_ROW];
  logic            lv [NUM_ROW];
  logic [IN_W-1:0] tw [NUM_COL];
  logic            tv [NUM_COL];

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_lskew
    if (r == 0) begin : g_direct
      assign lx[r] = left_in[r*IN_W +: IN_W];
      assign lv[r] = beat_fire;
    end else begin : g_chain
      logic [IN_W-1:0] d_q [r];
      logic [r-1:0]    v_q;
      // Delay left lane r by r cycles so it meets its column operands on the wavefront.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) d_q[i] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= left_in[r*IN_W +: IN_W];
          v_q[0] <= beat_fire;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign lx[r] = d_q[r-1];
      assign lv[r] = v_q[r-1];
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_tskew
    if (c == 0) begin : g_direct
      assign tw[c] = top_in[c*IN_W +: IN_W];
      assign tv[c] = beat_fire;
    end else begin : g_chain
      logic [IN_W-1:0] d_q [c];
      logic [c-1:0]    v_q;
      // Delay top lane c by c cycles so it meets its row operands on the wavefront.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) d_q[i] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= top_in[c*IN_W +: IN_W];
          v_q[0] <= beat_fire;
          for (int i = 1; i < c; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign tw[c] = d_q[c-1];
      assign tv[c] = v_q[c-1];
    end
  end

  // Horizontal (x) and vertical (w) links between neighbouring PEs.
  logic [IN_W-1:0] xh  [NUM_ROW][NUM_COL+1];
  logic            xvh [NUM_ROW][NUM_COL+1];
  logic [IN_W-1:0] wh  [NUM_ROW+1][NUM_COL];
  logic            wvh [NUM_ROW+1][NUM_COL];

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    assign xh[r][0]  = lx[r];
    assign xvh[r][0] = lv[r];
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      if (r == 0) begin : g_top_edge
        assign wh[0][c]  = tw[c];
        assign wvh[0][c] = tv[c];
      end
      sa_pe #(
        .IN_W   (IN_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .x_i     (xh[r][c]),
        .x_v_i   (xvh[r][c]),
        .w_i     (wh[r][c]),
        .w_v_i   (wvh[r][c]),
        .x_o     (xh[r][c+1]),
        .x_v_o   (xvh[r][c+1]),
        .w_o     (wh[r+1][c]),
        .w_v_o   (wvh[r+1][c]),
        .acc_o   (result[res_idx(r, c, NUM_COL)*ACC_W +: ACC_W])
`ifdef SA_SATURATE_EN
        ,
        .sat_o   (sat_flag[res_idx(r, c, NUM_COL)])
`endif
      );
    end
  end

endmodule
